// File: rtl/ucie_debug_stream_capture.sv
// Debug stream capture: filters device debug beats by type, keeps a circular
// pre-trigger history, then stores a fixed number of post-trigger beats for readout.
module ucie_debug_stream_capture #(
  parameter int          DEPTH      = 8,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] TS_RESET   = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cap_enable,
  output logic                    stream_enable,
  input  logic [DATA_WIDTH-1:0]   stream_data,
  input  logic                    stream_valid,
  input  logic [3:0]              stream_type,
  output logic                    stream_ready,
  input  logic [15:0]             type_mask,
  input  logic [3:0]              trig_type,
  input  logic                    trig_arm,
  input  logic [7:0]              post_trig_count,
  input  logic                    rd_req,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [3:0]              rd_type,
  output logic [31:0]             rd_ts,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [1:0]              cap_state,
  output logic                    triggered,
  output logic [15:0]             drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + 4 + 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                  state_q;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             level_q, level_d;
  logic [15:0]             drop_q, drop_d;
  logic [7:0]              post_q;
  logic [31:0]             ts_q;
  logic                    se_q;
  logic                    trig_q;
  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [3:0]              rd_type_q;
  logic [31:0]             rd_ts_q;
  logic [EW-1:0]           mem_q [DEPTH];

  logic full, empty, accept, store, pop, overwrite, is_trig, arm;

  assign full      = (level_q == (AW+1)'(DEPTH));
  assign empty     = (level_q == '0);
  assign stream_ready = cap_enable && ((state_q == ARMED) || ((state_q == CAPTURE) && !full));
  assign accept    = stream_valid && stream_ready;
  assign store     = accept && type_mask[stream_type];
  assign pop       = rd_req && !empty;
  // Only reachable in ARMED: CAPTURE deasserts ready while full.
  assign overwrite = store && full && !pop;
  assign is_trig   = store && (stream_type == trig_type);
  assign arm       = cap_enable && trig_arm && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    wr_ptr_d = store ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = (pop || overwrite) ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (store && !pop && !full) begin
      level_d = level_q + (AW+1)'(1);
    end else if (pop && !store) begin
      level_d = level_q - (AW+1)'(1);
    end
    drop_d = (overwrite && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    if (arm) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      drop_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_ptr_q] <= {stream_data, stream_type, ts_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_q     <= '0;
      post_q     <= '0;
      ts_q       <= TS_RESET;
      se_q       <= 1'b0;
      trig_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_type_q  <= '0;
      rd_ts_q    <= '0;
    end else begin
      ts_q       <= ts_q + 32'd1;
      se_q       <= cap_enable;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_q     <= drop_d;
      rd_valid_q <= pop;
      if (pop) begin
        {rd_data_q, rd_type_q, rd_ts_q} <= mem_q[rd_ptr_q];
      end
      if (!cap_enable) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (trig_arm) begin
              state_q <= ARMED;
              trig_q  <= 1'b0;
              post_q  <= '0;
            end
          end
          ARMED: begin
            if (is_trig) begin
              trig_q  <= 1'b1;
              post_q  <= post_trig_count;
              state_q <= (post_trig_count == 8'd0) ? DONE : CAPTURE;
            end
          end
          CAPTURE: begin
            // post_q is never 0 here; the beat taking it to 0 is the last stored.
            if (store) begin
              post_q <= post_q - 8'd1;
              if (post_q == 8'd1) begin
                state_q <= DONE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign stream_enable = se_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign rd_type       = rd_type_q;
  assign rd_ts         = rd_ts_q;
  assign fifo_level    = level_q;
  assign cap_state     = state_q;
  assign triggered     = trig_q;
  assign drop_count    = drop_q;
endmodule

// File: tb/tb_ucie_debug_stream_capture.sv
// Bench for ucie_debug_stream_capture: directed scenarios plus random traffic,
// all checked against a queue-based reference model of the capture rules.
module tb_ucie_debug_stream_capture;
  localparam int          DEPTH = 8;
  localparam int          DW    = 32;
  localparam logic [31:0] TS0   = 32'hFFFF_FFF8;

  logic          clk;
  logic          rst_n;
  logic          cap_enable;
  logic          stream_enable;
  logic [DW-1:0] stream_data;
  logic          stream_valid;
  logic [3:0]    stream_type;
  logic          stream_ready;
  logic [15:0]   type_mask;
  logic [3:0]    trig_type;
  logic          trig_arm;
  logic [7:0]    post_trig_count;
  logic          rd_req;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [3:0]    rd_type;
  logic [31:0]   rd_ts;
  logic [3:0]    fifo_level;
  logic [1:0]    cap_state;
  logic          triggered;
  logic [15:0]   drop_count;

  ucie_debug_stream_capture #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .TS_RESET(TS0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cap_enable(cap_enable), .stream_enable(stream_enable),
    .stream_data(stream_data), .stream_valid(stream_valid), .stream_type(stream_type),
    .stream_ready(stream_ready), .type_mask(type_mask), .trig_type(trig_type),
    .trig_arm(trig_arm), .post_trig_count(post_trig_count), .rd_req(rd_req),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_type(rd_type), .rd_ts(rd_ts),
    .fifo_level(fifo_level), .cap_state(cap_state), .triggered(triggered),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase codes 0 idle, 1 armed, 2 capture, 3 done.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [3:0]    t;
    logic [31:0]   ts;
  } ent_t;

  ent_t        q[$];
  int          m_phase;
  int          m_post;
  bit          m_trig;
  int          m_drop;
  logic [31:0] m_ts;
  bit          m_se;
  bit          m_rdv;
  ent_t        m_rd;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return cap_enable && (m_phase == 1 || (m_phase == 2 && q.size() < DEPTH));
  endfunction

  task automatic model_step();
    bit   store;
    ent_t e;
    store = stream_valid && model_ready() && type_mask[stream_type];
    m_rdv = 1'b0;
    if (rd_req && q.size() > 0) begin
      m_rd  = q.pop_front();
      m_rdv = 1'b1;
    end
    if (store) begin
      if (q.size() == DEPTH) begin
        void'(q.pop_front());
        if (m_drop < 65535) m_drop++;
      end
      e.d = stream_data; e.t = stream_type; e.ts = m_ts;
      q.push_back(e);
    end
    m_ts = m_ts + 32'd1;
    m_se = cap_enable;
    if (!cap_enable) begin
      m_phase = 0;
    end else if ((m_phase == 0 || m_phase == 3) && trig_arm) begin
      q.delete(); m_trig = 0; m_drop = 0; m_post = 0; m_phase = 1;
    end else if (m_phase == 1 && store && stream_type == trig_type) begin
      m_trig = 1;
      if (post_trig_count == 0) m_phase = 3;
      else begin m_phase = 2; m_post = post_trig_count; end
    end else if (m_phase == 2 && store) begin
      m_post--;
      if (m_post == 0) m_phase = 3;
    end
  endtask

  task automatic check_outputs();
    check_eq("cap_state", cap_state, m_phase);
    check_eq("fifo_level", fifo_level, q.size());
    check_eq("triggered", triggered, m_trig);
    check_eq("drop_count", drop_count, m_drop);
    check_eq("stream_enable", stream_enable, m_se);
    check_eq("rd_valid", rd_valid, m_rdv);
    if (m_rdv) begin
      check_eq("rd_data", rd_data, m_rd.d);
      check_eq("rd_type", rd_type, m_rd.t);
      check_eq("rd_ts", rd_ts, m_rd.ts);
      $display("[TB] pop data=%h type=%0d ts=%h level=%0d", rd_data, rd_type, rd_ts, fifo_level);
    end
  endtask

  task automatic tick();
    #1;
    check_eq("stream_ready", stream_ready, model_ready());
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic clear_inputs();
    cap_enable = 0; stream_data = '0; stream_valid = 0; stream_type = '0;
    type_mask = '0; trig_type = '0; trig_arm = 0; post_trig_count = '0; rd_req = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    check_eq("rst_state", cap_state, 0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_ready", stream_ready, 0);
    check_eq("rst_se", stream_enable, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_fields", {rd_data, rd_type, rd_ts}, 0);
    check_eq("rst_trig_drop", {triggered, drop_count}, 0);
    q.delete(); m_phase = 0; m_post = 0; m_trig = 0; m_drop = 0;
    m_ts = TS0; m_se = 0; m_rdv = 0; m_rd = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    $display("[TB] reset applied");
  endtask

  task automatic beat(input logic [3:0] t, input logic [DW-1:0] d);
    stream_valid = 1; stream_type = t; stream_data = d;
    tick();
    stream_valid = 0;
  endtask

  task automatic arm(input logic [15:0] mask, input logic [3:0] tt, input logic [7:0] post);
    cap_enable = 1; type_mask = mask; trig_type = tt; post_trig_count = post; trig_arm = 1;
    tick();
    trig_arm = 0;
  endtask

  initial begin
    logic [3:0]  seq1 [7];
    logic [3:0]  seq4 [4];
    logic [DW-1:0] d6 [3];
    seq1 = '{4'd1, 4'd2, 4'd5, 4'd3, 4'd4, 4'd6, 4'd7};
    seq4 = '{4'd1, 4'd2, 4'd2, 4'd3};
    rst_n = 1'b1;
    clear_inputs();
    #2;

    // Trigger with post=3: six stored, DONE after type 6, type 7 refused.
    do_reset();
    cap_enable = 1; tick();
    arm(16'hFFFF, 4'd5, 8'd3);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin
        #1 check_eq("s1_ready_done", stream_ready, 0);
      end
      beat(seq1[i], $urandom);
    end
    check_eq("s1_state", cap_state, 3);
    check_eq("s1_level", fifo_level, 6);
    rd_req = 1; repeat (6) tick(); rd_req = 0; tick();

    // Circular pre-trigger buffer: 11 beats into 8 entries.
    do_reset();
    arm(16'hFFFF, 4'd15, 8'd2);
    for (int k = 1; k <= 11; k++) beat(4'(k % 15), k);
    check_eq("s2_level", fifo_level, 8);
    check_eq("s2_drop", drop_count, 3);
    rd_req = 1; tick(); rd_req = 0;
    check_eq("s2_head", rd_data, 4);

    // Full in CAPTURE: backpressure, no drop; one pop frees a slot.
    do_reset();
    arm(16'hFFFF, 4'd5, 8'd20);
    beat(4'd5, 32'h500);
    for (int k = 0; k < 7; k++) beat(4'd1, 32'h100 + k);
    stream_valid = 1; stream_type = 4'd1; stream_data = 32'h1FF;
    repeat (2) tick();
    check_eq("s3_ready_full", stream_ready, 0);
    check_eq("s3_drop", drop_count, 0);
    rd_req = 1; tick(); rd_req = 0;
    check_eq("s3_ready_back", stream_ready, 1);
    tick();
    stream_valid = 0;
    check_eq("s3_level", fifo_level, 8);
    check_eq("s3_state", cap_state, 2);

    // Type filter: only type-2 beats kept; then trigger on type 2 with post=0.
    do_reset();
    arm(16'h0004, 4'd9, 8'd0);
    for (int i = 0; i < 4; i++) beat(seq4[i], 32'h40 + i);
    check_eq("s4_level_filter", fifo_level, 2);
    cap_enable = 0; tick();
    arm(16'h0004, 4'd2, 8'd0);
    for (int i = 0; i < 4; i++) beat(seq4[i], 32'h50 + i);
    check_eq("s4_state_done", cap_state, 3);
    check_eq("s4_level_trig", fifo_level, 1);
    check_eq("s4_triggered", triggered, 1);

    // Timestamp wrap: beats land at reset-relative edges 7 and 8.
    do_reset();
    arm(16'hFFFF, 4'd15, 8'd1);
    repeat (6) tick();
    beat(4'd1, 32'hAAAA);
    beat(4'd1, 32'hBBBB);
    rd_req = 1;
    tick(); check_eq("s5_ts_first", rd_ts, 32'hFFFF_FFFF);
    tick(); check_eq("s5_ts_second", rd_ts, 32'h0000_0000);
    rd_req = 0;

    // Enable dropped mid-capture: IDLE next cycle, contents retained in order.
    do_reset();
    arm(16'hFFFF, 4'd5, 8'd4);
    d6 = '{32'hA0, 32'hA1, 32'hA2};
    beat(4'd5, d6[0]); beat(4'd1, d6[1]); beat(4'd2, d6[2]);
    cap_enable = 0; tick();
    check_eq("s6_state_idle", cap_state, 0);
    check_eq("s6_ready", stream_ready, 0);
    rd_req = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("s6_order", rd_data, d6[i]);
    end
    rd_req = 0;

    // Reset mid-capture discards contents.
    do_reset();
    arm(16'hFFFF, 4'd5, 8'd4);
    beat(4'd5, 32'h77); beat(4'd1, 32'h78);
    do_reset();
    rd_req = 1; repeat (2) tick(); rd_req = 0;
    check_eq("s7_rd_empty", rd_valid, 0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) begin
        trig_type       = 4'($urandom);
        type_mask       = 16'($urandom) | (16'd1 << trig_type);
        post_trig_count = 8'($urandom_range(0, 4));
      end
      cap_enable   = ($urandom % 20) != 0;
      trig_arm     = ($urandom % 10) == 0;
      stream_valid = $urandom % 2;
      stream_type  = ($urandom % 3 == 0) ? trig_type : 4'($urandom);
      stream_data  = $urandom;
      rd_req       = ($urandom % 3) == 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
